// File: rtl/fabric_egress_replicator.sv
// Egress replicator: delivers each frame of the forwarding stream to one egress port
// (unicast) or to every up port except the ingress port (flood), one beat at a time.
module fabric_egress_replicator #(
  parameter int NUM_PORTS      = 24,
  parameter int DROP_CTR_WIDTH = 32
) (
  input  logic                      clk_fabric,
  input  logic                      areset_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [63:0]               s_tdata,
  input  logic [7:0]                s_tkeep,
  input  logic                      s_tlast,
  input  logic [6:0]                s_tdest,
  input  logic [11:0]               s_tuser,
  input  logic [NUM_PORTS-1:0]      port_up,
  output logic [NUM_PORTS-1:0]      m_tvalid,
  input  logic [NUM_PORTS-1:0]      m_tready,
  output logic [63:0]               m_tdata,
  output logic [7:0]                m_tkeep,
  output logic                      m_tlast,
  output logic [11:0]               m_tuser,
  output logic [DROP_CTR_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [DROP_CTR_WIDTH-1:0] CTR_ONE = {{(DROP_CTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DROP_CTR_WIDTH-1:0] CTR_MAX = {DROP_CTR_WIDTH{1'b1}};

  state_t                      state_r, state_s;
  logic                        hold_valid_r;
  logic [63:0]                 data_r;
  logic [7:0]                  keep_r;
  logic                        last_r;
  logic [11:0]                 user_r;
  logic [NUM_PORTS-1:0]        pend_r, tgt_r;
  logic [DROP_CTR_WIDTH-1:0]   drop_count_r;

  logic [NUM_PORTS-1:0]        onehot_s, tgt_new_s, tgt_use_s;
  logic                        sof_s, beat_complete_s, drop_beat_s;
  logic                        s_tready_s, accept_s, load_s;

  // Target mask decode from TDEST/port_up; an out-of-range index matches no port.
  always_comb begin
    onehot_s  = '0;
    tgt_new_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      onehot_s[p] = (s_tdest[5:0] == 6'(p));
    end
    if (s_tdest[6]) begin
      tgt_new_s = port_up & ~onehot_s;
    end else begin
      tgt_new_s = port_up & onehot_s;
    end
  end

  // Input handshake: the hold register frees up when every pending port takes the beat.
  always_comb begin
    sof_s           = (state_r == IDLE);
    tgt_use_s       = sof_s ? tgt_new_s : tgt_r;
    beat_complete_s = hold_valid_r && ((pend_r & ~m_tready) == '0);
    if (sof_s) begin
      drop_beat_s = (tgt_new_s == '0);
    end else begin
      drop_beat_s = (state_r == DROP);
    end
    if (state_r == DROP) begin
      s_tready_s = 1'b1;
    end else begin
      s_tready_s = !hold_valid_r || beat_complete_s;
    end
    accept_s = s_tvalid && s_tready_s;
    load_s   = accept_s && !drop_beat_s;
  end

  // Frame FSM next state; a single-beat frame never leaves IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !s_tlast) begin
          state_s = drop_beat_s ? DROP : FWD;
        end else begin
          state_s = IDLE;
        end
      end
      FWD, DROP: begin
        if (accept_s && s_tlast) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and per-frame target mask latched on the first beat.
  always_ff @(posedge clk_fabric or negedge areset_n) begin
    if (!areset_n) begin
      state_r <= IDLE;
      tgt_r   <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s && sof_s) begin
        tgt_r <= tgt_new_s;
      end
    end
  end

  // Hold register and per-port pending mask; a new beat reloads pend in the completing edge.
  always_ff @(posedge clk_fabric or negedge areset_n) begin
    if (!areset_n) begin
      hold_valid_r <= 1'b0;
      data_r       <= 64'd0;
      keep_r       <= 8'd0;
      last_r       <= 1'b0;
      user_r       <= 12'd0;
      pend_r       <= '0;
    end else begin
      if (load_s) begin
        hold_valid_r <= 1'b1;
        data_r       <= s_tdata;
        keep_r       <= s_tkeep;
        last_r       <= s_tlast;
        user_r       <= s_tuser;
        pend_r       <= tgt_use_s;
      end else begin
        if (beat_complete_s) begin
          hold_valid_r <= 1'b0;
        end
        pend_r <= pend_r & ~(m_tvalid & m_tready);
      end
    end
  end

  // Saturating count of discarded frames, bumped on the first beat only.
  always_ff @(posedge clk_fabric or negedge areset_n) begin
    if (!areset_n) begin
      drop_count_r <= '0;
    end else if (accept_s && sof_s && drop_beat_s && (drop_count_r != CTR_MAX)) begin
      drop_count_r <= drop_count_r + CTR_ONE;
    end
  end

  assign s_tready   = s_tready_s;
  assign m_tvalid   = hold_valid_r ? pend_r : '0;
  assign m_tdata    = data_r;
  assign m_tkeep    = keep_r;
  assign m_tlast    = last_r;
  assign m_tuser    = user_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_fabric_egress_replicator.sv
// Bench for fabric_egress_replicator: per-port expected-beat queues checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fabric_egress_replicator;

  localparam int N    = 24;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk_fabric = 1'b0;
  logic           areset_n;
  logic           s_tvalid, s_tready, s_tlast, m_tlast;
  logic [63:0]    s_tdata, m_tdata;
  logic [7:0]     s_tkeep, m_tkeep;
  logic [6:0]     s_tdest;
  logic [11:0]    s_tuser, m_tuser;
  logic [N-1:0]   port_up, m_tvalid, m_tready;
  logic [CW-1:0]  drop_count;

  fabric_egress_replicator #(.NUM_PORTS(N), .DROP_CTR_WIDTH(CW)) dut (
    .clk_fabric(clk_fabric), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tdest(s_tdest), .s_tuser(s_tuser), .port_up(port_up),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .drop_count(drop_count)
  );

  always #5 clk_fabric = ~clk_fabric;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [11:0] u;
  } beat_t;

  beat_t        q [N][$];
  bit           in_frame, frame_drop, acc_last, rdy_rand, up_rand;
  logic [N-1:0] ftgt;
  logic         exp_ready;
  int           exp_cnt, n_cmp, n_err;
  logic [N-1:0] last_mv;
  logic         last_sr, last_ml;
  logic [11:0]  last_mu;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N; p++) q[p].delete();
    in_frame   = 1'b0;
    frame_drop = 1'b0;
    exp_cnt    = 0;
  endtask

  // Every-cycle comparison of DUT outputs against the queue model.
  task automatic compare();
    logic [N-1:0] em;
    bit done;
    em = '0;
    done = 1'b0;
    for (int p = 0; p < N; p++) if (q[p].size() != 0) em[p] = 1'b1;
    exp_ready = (in_frame && frame_drop) ? 1'b1 : ((em & ~m_tready) == '0);
    check("m_tvalid", 64'(m_tvalid), 64'(em));
    check("s_tready", 64'(s_tready), 64'(exp_ready));
    check("drop_count", 64'(drop_count), 64'(exp_cnt));
    for (int p = 0; p < N; p++) begin
      if (!done && q[p].size() != 0) begin
        done = 1'b1;
        check("m_tdata", m_tdata, q[p][0].d);
        check("m_tkeep", 64'(m_tkeep), 64'(q[p][0].k));
        check("m_tlast", 64'(m_tlast), 64'(q[p][0].l));
        check("m_tuser", 64'(m_tuser), 64'(q[p][0].u));
      end
    end
    last_mv = m_tvalid;
    last_sr = s_tready;
    last_ml = m_tlast;
    last_mu = m_tuser;
  endtask

  // Model step: ports that are ready take their owed beat; an accepted beat is queued
  // to every port in the frame's target set.
  task automatic advance();
    logic [N-1:0] tgt;
    beat_t b;
    acc_last = 1'b0;
    if (areset_n) begin
      for (int p = 0; p < N; p++) if (q[p].size() != 0 && m_tready[p]) void'(q[p].pop_front());
      if (s_tvalid && exp_ready) begin
        acc_last = 1'b1;
        b = {s_tdata, s_tkeep, s_tlast, s_tuser};
        if (!in_frame) begin
          tgt = '0;
          for (int p = 0; p < N; p++) begin
            if (port_up[p]) begin
              if (s_tdest[6]) tgt[p] = (int'(s_tdest[5:0]) != p);
              else            tgt[p] = (int'(s_tdest[5:0]) == p);
            end
          end
          ftgt       = tgt;
          frame_drop = (tgt == '0);
          if (frame_drop && exp_cnt < CMAX) exp_cnt++;
        end
        if (!frame_drop) for (int p = 0; p < N; p++) if (ftgt[p]) q[p].push_back(b);
        in_frame = !s_tlast;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk_fabric);
    compare();
    advance();
    @(posedge clk_fabric);
    #1;
    if (rdy_rand) m_tready = N'($urandom() | $urandom());
    if (up_rand && $urandom_range(0, 3) == 0) port_up = N'($urandom() | $urandom() | $urandom());
  endtask

  task automatic drive(input logic [6:0] dest, input logic [11:0] user, input logic last);
    s_tvalid = 1'b1;
    s_tdest  = dest;
    s_tuser  = user;
    s_tdata  = {$urandom(), $urandom()};
    s_tkeep  = 8'($urandom());
    s_tlast  = last;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) cycle();
  endtask

  // Sends a frame; later beats carry junk TDEST, which must be ignored.
  task automatic send_frame(input logic [6:0] dest, input logic [11:0] user, input int nbeats, input int maxgap);
    int budget;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, maxgap)) begin
        s_tvalid = 1'b0;
        cycle();
      end
      drive((b == 0) ? dest : 7'($urandom()), user, (b == nbeats - 1));
      budget = 0;
      do begin
        cycle();
        budget++;
      end while (!acc_last && budget < 400);
      if (!acc_last) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", b, budget);
      end
    end
    s_tvalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] low;
    n_cmp = 0; n_err = 0;
    rdy_rand = 1'b0; up_rand = 1'b0;
    areset_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = 64'd0; s_tkeep = 8'd0; s_tlast = 1'b0;
    s_tdest = 7'd0; s_tuser = 12'd0;
    port_up = '1; m_tready = '1;
    model_reset();
    repeat (3) cycle();
    check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_m_tlast", 64'(m_tlast), 64'h0);
    check("rst_m_tuser", 64'(m_tuser), 64'h0);
    check("rst_drop_count", 64'(drop_count), 64'h0);
    areset_n = 1'b1;
    idle(2);

    // Unicast to port 5, 3 beats, VLAN 69.
    drive(7'h05, 12'd69, 1'b0); cycle();
    drive(7'h05, 12'd69, 1'b0); cycle(); check("uc_b0_valid", 64'(last_mv), 64'h20);
    drive(7'h05, 12'd69, 1'b1); cycle(); check("uc_b1_valid", 64'(last_mv), 64'h20);
    s_tvalid = 1'b0;            cycle(); check("uc_b2_valid", 64'(last_mv), 64'h20);
    check("uc_b2_last", 64'(last_ml), 64'h1);
    check("uc_b2_user", 64'(last_mu), 64'd69);
    cycle(); check("uc_done_valid", 64'(last_mv), 64'h0);
    check("uc_drop_count", 64'(drop_count), 64'h0);

    // Flood from ingress port 1.
    drive(7'h41, 12'd7, 1'b0); cycle();
    drive(7'h41, 12'd7, 1'b1); cycle(); check("flood_b0_valid", 64'(last_mv), 64'hFFFFFD);
    s_tvalid = 1'b0;           cycle(); check("flood_b1_valid", 64'(last_mv), 64'hFFFFFD);
    idle(2);

    // Flood from port 0 with port 3 stalled for four cycles.
    drive(7'h40, 12'd9, 1'b0); cycle();
    m_tready = 24'hFFFFF7;
    drive(7'h40, 12'd9, 1'b1); cycle();
    check("skew_c1_valid", 64'(last_mv), 64'hFFFFFE);
    check("skew_c1_ready", 64'(last_sr), 64'h0);
    for (int i = 2; i <= 4; i++) begin
      cycle();
      check("skew_hold_valid", 64'(last_mv), 64'h8);
      check("skew_hold_ready", 64'(last_sr), 64'h0);
    end
    m_tready = '1;
    cycle();
    check("skew_c5_valid", 64'(last_mv), 64'h8);
    check("skew_c5_ready", 64'(last_sr), 64'h1);
    s_tvalid = 1'b0; cycle(); check("skew_b1_valid", 64'(last_mv), 64'hFFFFFE);
    idle(2);

    // Drops: port 7 down, then an out-of-range unicast index.
    port_up = 24'hFFFF7F;
    drive(7'h07, 12'd3, 1'b0); cycle(); check("drop_a0_ready", 64'(last_sr), 64'h1);
    drive(7'h07, 12'd3, 1'b1); cycle(); check("drop_a1_ready", 64'(last_sr), 64'h1);
    check("drop_a1_valid", 64'(last_mv), 64'h0);
    port_up = '1;
    drive(7'h30, 12'd3, 1'b1); cycle(); check("drop_b_ready", 64'(last_sr), 64'h1);
    s_tvalid = 1'b0; cycle(); check("drop_b_valid", 64'(last_mv), 64'h0);
    check("drop_count_2", 64'(drop_count), 64'h2);

    // Back-to-back single-beat unicasts to ports 4 and 9.
    drive(7'h04, 12'd1, 1'b1); cycle();
    drive(7'h09, 12'd2, 1'b1); cycle();
    check("b2b_p4_valid", 64'(last_mv), 64'h10);
    check("b2b_ready", 64'(last_sr), 64'h1);
    s_tvalid = 1'b0; cycle(); check("b2b_p9_valid", 64'(last_mv), 64'h200);
    idle(2);

    // Reset during beat 2 of a 5-beat flood.
    drive(7'h40, 12'd5, 1'b0); cycle();
    drive(7'h40, 12'd5, 1'b0); cycle();
    drive(7'h40, 12'd5, 1'b0);
    #2;
    areset_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(m_tvalid), 64'h0);
    model_reset();
    s_tvalid = 1'b0;
    repeat (2) cycle();
    areset_n = 1'b1;
    idle(2);
    drive(7'h02, 12'd11, 1'b0); cycle();
    drive(7'h02, 12'd11, 1'b1); cycle(); check("post_rst_b0_valid", 64'(last_mv), 64'h4);
    s_tvalid = 1'b0;            cycle(); check("post_rst_b1_valid", 64'(last_mv), 64'h4);
    idle(2);

    // Saturate the drop counter.
    for (int i = 0; i < 17; i++) send_frame(7'h3F, 12'd0, 1, 0);
    idle(1);
    check("drop_count_sat", 64'(drop_count), 64'hF);

    // Randomized traffic with random backpressure and port_up churn.
    rdy_rand = 1'b1;
    up_rand  = 1'b1;
    for (int i = 0; i < 250; i++) begin
      low = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 25));
      send_frame({1'($urandom_range(0, 1)), low}, 12'($urandom()), $urandom_range(1, 4), 2);
    end
    rdy_rand = 1'b0;
    up_rand  = 1'b0;
    m_tready = '1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
